// File: rtl/lsu_mem_port_if.sv
// Bundle of the load/store unit signals: the request/response handshake with
// the execute stage and the word-addressed block RAM port.
//   master : execute side + RAM model (drives requests and mem_rdata)
//   slave  : the load/store unit (drives ready/response and the RAM controls)
// Signals:
//   req_valid/req_ready, MemRead, MemWrite, func3, addr, w_data : request
//   resp_valid, r_data, err                                     : response
//   mem_en, mem_addr, mem_we, mem_wdata, mem_rdata              : RAM port
interface lsu_mem_port_if #(
  parameter int ADDR_W = 8
);
  logic              req_valid;
  logic              req_ready;
  logic              MemRead;
  logic              MemWrite;
  logic [2:0]        func3;
  logic [31:0]       addr;
  logic [31:0]       w_data;
  logic              resp_valid;
  logic [31:0]       r_data;
  logic              err;
  logic              mem_en;
  logic [ADDR_W-1:0] mem_addr;
  logic [3:0]        mem_we;
  logic [31:0]       mem_wdata;
  logic [31:0]       mem_rdata;

  modport master (
    output req_valid, MemRead, MemWrite, func3, addr, w_data, mem_rdata,
    input  req_ready, resp_valid, r_data, err, mem_en, mem_addr, mem_we, mem_wdata
  );

  modport slave (
    input  req_valid, MemRead, MemWrite, func3, addr, w_data, mem_rdata,
    output req_ready, resp_valid, r_data, err, mem_en, mem_addr, mem_we, mem_wdata
  );
endinterface

// File: rtl/lsu_mem_port.sv
// Load/store unit between execute and a synchronous block RAM (1-cycle read).
// Accepts one load/store at a time, splits word-crossing accesses into two
// RAM accesses, merges and extends load data, and reports illegal requests.
// Ports:
//   clk   : clock, all state on rising edge
//   rst_n : asynchronous active-low reset
//   bus   : lsu_mem_port_if.slave (request, response and RAM port signals)
module lsu_mem_port #(
  parameter int ADDR_W   = 8,
  parameter bit SPLIT_EN = 1'b1
) (
  input logic           clk,
  input logic           rst_n,
  lsu_mem_port_if.slave bus
);

  typedef enum logic [2:0] {IDLE, ACC0, ACC1, CAP, RESP} state_t;

  state_t            state_q, state_d;
  logic [2:0]        func3_q, func3_d;
  logic [ADDR_W+1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [31:0]       lo_q, lo_d;
  logic [31:0]       hi_q, hi_d;
  logic              wr_q, wr_d;
  logic              split_q, split_d;
  logic              err_q, err_d;

  function automatic logic [2:0] size_of(input logic [2:0] f3);
    case (f3[1:0])
      2'd0:    return 3'd1;
      2'd1:    return 3'd2;
      default: return 3'd4;
    endcase
  endfunction

  function automatic logic [3:0] lane_mask(input logic [2:0] f3);
    case (f3[1:0])
      2'd0:    return 4'b0001;
      2'd1:    return 4'b0011;
      default: return 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] load_extend(input logic [2:0] f3, input logic [31:0] rd);
    case (f3)
      3'd0:    return {{24{rd[7]}}, rd[7:0]};
      3'd1:    return {{16{rd[15]}}, rd[15:0]};
      3'd4:    return {24'b0, rd[7:0]};
      3'd5:    return {16'b0, rd[15:0]};
      default: return rd;
    endcase
  endfunction

  // Request decode, evaluated on the live request while idle
  logic [3:0] req_end;
  logic       req_split, req_illegal, accept;
  logic       unused_addr_hi;

  assign unused_addr_hi = ^bus.addr[31:ADDR_W+2];
  assign req_end        = {2'b0, bus.addr[1:0]} + {1'b0, size_of(bus.func3)};
  assign req_split      = (req_end > 4'd4);
  assign req_illegal    = (bus.MemRead && bus.MemWrite)
                       || (bus.func3 == 3'd3) || (bus.func3 == 3'd6) || (bus.func3 == 3'd7)
                       || (bus.MemWrite && ((bus.func3 == 3'd4) || (bus.func3 == 3'd5)))
                       || (req_split && !SPLIT_EN);
  assign accept         = bus.req_valid && (state_q == IDLE) && (bus.MemRead || bus.MemWrite);

  // Lane steering from the latched request; the 64-bit views span word0:word1
  logic [ADDR_W-1:0] word0;
  logic [7:0]        be8;
  logic [63:0]       wd64;
  logic [31:0]       rd_merged;

  assign word0     = addr_q[ADDR_W+1:2];
  assign be8       = {4'b0, lane_mask(func3_q)} << addr_q[1:0];
  assign wd64      = {32'b0, wdata_q} << {addr_q[1:0], 3'b000};
  assign rd_merged = 32'({hi_q, lo_q} >> {addr_q[1:0], 3'b000});

  always_comb begin
    state_d = state_q;
    func3_d = func3_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    wr_d    = wr_q;
    split_d = split_q;
    err_d   = err_q;
    lo_d    = lo_q;
    hi_d    = hi_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          func3_d = bus.func3;
          addr_d  = bus.addr[ADDR_W+1:0];
          wdata_d = bus.w_data;
          wr_d    = bus.MemWrite;
          split_d = req_split;
          err_d   = req_illegal;
          lo_d    = '0;
          hi_d    = '0;
          state_d = req_illegal ? RESP : ACC0;
        end
      end
      ACC0: state_d = split_q ? ACC1 : (wr_q ? RESP : CAP);
      ACC1: begin
        // mem_rdata here is the word0 read issued in ACC0
        if (!wr_q) lo_d = bus.mem_rdata;
        state_d = wr_q ? RESP : CAP;
      end
      CAP: begin
        if (split_q) hi_d = bus.mem_rdata;
        else         lo_d = bus.mem_rdata;
        state_d = RESP;
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    bus.mem_en    = 1'b0;
    bus.mem_addr  = '0;
    bus.mem_we    = 4'b0;
    bus.mem_wdata = '0;
    case (state_q)
      ACC0: begin
        bus.mem_en   = 1'b1;
        bus.mem_addr = word0;
        if (wr_q) begin
          bus.mem_we    = be8[3:0];
          bus.mem_wdata = wd64[31:0];
        end
      end
      ACC1: begin
        bus.mem_en   = 1'b1;
        bus.mem_addr = word0 + ADDR_W'(1);
        if (wr_q) begin
          bus.mem_we    = be8[7:4];
          bus.mem_wdata = wd64[63:32];
        end
      end
      default: ;
    endcase
  end

  assign bus.req_ready  = (state_q == IDLE);
  assign bus.resp_valid = (state_q == RESP);
  assign bus.err        = (state_q == RESP) && err_q;
  assign bus.r_data     = ((state_q == RESP) && !err_q && !wr_q) ? load_extend(func3_q, rd_merged) : 32'b0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      func3_q <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      wr_q    <= 1'b0;
      split_q <= 1'b0;
      err_q   <= 1'b0;
      lo_q    <= '0;
      hi_q    <= '0;
    end else begin
      state_q <= state_d;
      func3_q <= func3_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      wr_q    <= wr_d;
      split_q <= split_d;
      err_q   <= err_d;
      lo_q    <= lo_d;
      hi_q    <= hi_d;
    end
  end

endmodule

// File: tb/tb_lsu_mem_port.sv
// Testbench for lsu_mem_port: DUT A (SPLIT_EN=1) with a byte-enabled RAM
// model, DUT B (SPLIT_EN=0) with a constant read word. Expected responses and
// RAM accesses are queued at issue time and popped by negedge monitors.
module tb_lsu_mem_port;
  localparam int AW = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic ram_clr = 1'b1;
  int   cyc = 0;
  int   n_tests = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  lsu_mem_port_if #(.ADDR_W(AW)) ifa ();
  lsu_mem_port_if #(.ADDR_W(AW)) ifb ();

  lsu_mem_port #(.ADDR_W(AW), .SPLIT_EN(1'b1)) dut_a (.clk(clk), .rst_n(rst_n), .bus(ifa.slave));
  lsu_mem_port #(.ADDR_W(AW), .SPLIT_EN(1'b0)) dut_b (.clk(clk), .rst_n(rst_n), .bus(ifb.slave));

  logic [31:0] ram [0:255];
  always @(posedge clk) begin
    if (ram_clr) begin
      for (int i = 0; i < 256; i++) ram[i] <= 32'h0;
    end else if (ifa.mem_en) begin
      for (int b = 0; b < 4; b++)
        if (ifa.mem_we[b]) ram[ifa.mem_addr][8*b +: 8] <= ifa.mem_wdata[8*b +: 8];
      if (ifa.mem_we == 4'b0) ifa.mem_rdata <= ram[ifa.mem_addr];
    end
  end
  assign ifb.mem_rdata = 32'hCAFEF00D;

  typedef struct { logic [31:0] rdata; logic err; int cyc; } resp_t;
  typedef struct { logic [AW-1:0] addr; logic [3:0] we; logic [31:0] wdata; int cyc; } acc_t;
  resp_t rqa[$];
  resp_t rqb[$];
  acc_t  aqa[$];
  acc_t  aqb[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic flag_fail(input string name, input string what);
    n_tests++;
    n_fail++;
    $display("FAIL %s: %s (cycle %0d)", name, what, cyc);
  endtask

  always @(negedge clk) begin
    resp_t r;
    acc_t  a;
    if (ifa.resp_valid) begin
      if (rqa.size() == 0) flag_fail("A resp", "got resp_valid=1, expected none");
      else begin
        r = rqa.pop_front();
        chk("A r_data", ifa.r_data, r.rdata);
        chk("A err", {31'b0, ifa.err}, {31'b0, r.err});
        chk("A resp cycle", cyc, r.cyc);
      end
    end
    if (ifa.mem_en) begin
      if (aqa.size() == 0) flag_fail("A mem_en", "got mem_en=1, expected none");
      else begin
        a = aqa.pop_front();
        chk("A mem_addr", {24'b0, ifa.mem_addr}, {24'b0, a.addr});
        chk("A mem_we", {28'b0, ifa.mem_we}, {28'b0, a.we});
        if (a.we != 4'b0) chk("A mem_wdata", ifa.mem_wdata, a.wdata);
        chk("A mem cycle", cyc, a.cyc);
      end
    end else if (ifa.mem_we != 4'b0) begin
      flag_fail("A mem_we idle", "got nonzero mem_we with mem_en=0");
    end
    if (ifb.resp_valid) begin
      if (rqb.size() == 0) flag_fail("B resp", "got resp_valid=1, expected none");
      else begin
        r = rqb.pop_front();
        chk("B r_data", ifb.r_data, r.rdata);
        chk("B err", {31'b0, ifb.err}, {31'b0, r.err});
        chk("B resp cycle", cyc, r.cyc);
      end
    end
    if (ifb.mem_en) begin
      if (aqb.size() == 0) flag_fail("B mem_en", "got mem_en=1, expected none");
      else begin
        a = aqb.pop_front();
        chk("B mem_addr", {24'b0, ifb.mem_addr}, {24'b0, a.addr});
        chk("B mem_we", {28'b0, ifb.mem_we}, {28'b0, a.we});
        chk("B mem cycle", cyc, a.cyc);
      end
    end
  end

  task automatic drive(input logic vld_a, input logic vld_b, input logic rd, input logic wr,
                       input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd);
    ifa.req_valid = vld_a; ifa.MemRead = rd; ifa.MemWrite = wr;
    ifa.func3 = f3; ifa.addr = a; ifa.w_data = wd;
    ifb.req_valid = vld_b; ifb.MemRead = rd; ifb.MemWrite = wr;
    ifb.func3 = f3; ifb.addr = a; ifb.w_data = wd;
  endtask

  // One directed vector: request, expected response/latency, expected RAM accesses
  task automatic run(input bit on_b, input logic rd, input logic wr, input logic [2:0] f3,
                     input logic [31:0] a, input logic [31:0] wd,
                     input logic [31:0] exp_rd, input logic exp_err, input int lat, input int nacc,
                     input logic [AW-1:0] ma0, input logic [3:0] we0, input logic [31:0] wd0,
                     input logic [AW-1:0] ma1, input logic [3:0] we1, input logic [31:0] wd1);
    int n;
    int c;
    @(negedge clk);
    n = 0;
    while (!(on_b ? ifb.req_ready : ifa.req_ready) && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (n >= 20) flag_fail("req_ready wait", "req_ready stayed 0 for 20 cycles");
    c = cyc;
    if (on_b) begin
      rqb.push_back('{exp_rd, exp_err, c + lat});
      if (nacc > 0) aqb.push_back('{ma0, we0, wd0, c + 1});
      if (nacc > 1) aqb.push_back('{ma1, we1, wd1, c + 2});
    end else begin
      rqa.push_back('{exp_rd, exp_err, c + lat});
      if (nacc > 0) aqa.push_back('{ma0, we0, wd0, c + 1});
      if (nacc > 1) aqa.push_back('{ma1, we1, wd1, c + 2});
    end
    drive(!on_b, on_b, rd, wr, f3, a, wd);
    @(negedge clk);
    chk("req_ready busy", {31'b0, on_b ? ifb.req_ready : ifa.req_ready}, 32'h0);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 32'h0, 32'h0);
    n = 0;
    while ((rqa.size() + rqb.size() + aqa.size() + aqb.size()) != 0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (n >= 20) begin
      flag_fail("completion", "expected response or RAM access never appeared");
      rqa.delete(); rqb.delete(); aqa.delete(); aqb.delete();
    end
  endtask

  initial begin
    int c;
    drive(1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 32'h0, 32'h0);
    repeat (2) @(negedge clk);
    chk("reset req_ready", {31'b0, ifa.req_ready}, 32'h1);
    chk("reset resp_valid", {31'b0, ifa.resp_valid}, 32'h0);
    chk("reset mem_en", {31'b0, ifa.mem_en}, 32'h0);
    chk("reset r_data", ifa.r_data, 32'h0);
    chk("reset mem_we", {28'b0, ifa.mem_we}, 32'h0);
    ram_clr = 1'b0;
    rst_n = 1'b1;

    //   B  rd wr f3    addr           w_data         exp_rd         err lat n ma0    we0    wd0            ma1    we1    wd1
    run(0, 0, 1, 3'd2, 32'h0000_0010, 32'hDEADBEEF, 32'h0000_0000, 0, 2, 1, 8'h04, 4'hF, 32'hDEADBEEF, 8'h00, 4'h0, 32'h0);
    run(0, 1, 0, 3'd2, 32'h0000_0010, 32'h0,        32'hDEADBEEF, 0, 3, 1, 8'h04, 4'h0, 32'h0,        8'h00, 4'h0, 32'h0);
    run(0, 0, 1, 3'd2, 32'h0000_0010, 32'h80FF1122, 32'h0000_0000, 0, 2, 1, 8'h04, 4'hF, 32'h80FF1122, 8'h00, 4'h0, 32'h0);
    run(0, 1, 0, 3'd0, 32'h0000_0013, 32'h0,        32'hFFFFFF80, 0, 3, 1, 8'h04, 4'h0, 32'h0,        8'h00, 4'h0, 32'h0);
    run(0, 1, 0, 3'd4, 32'h0000_0013, 32'h0,        32'h00000080, 0, 3, 1, 8'h04, 4'h0, 32'h0,        8'h00, 4'h0, 32'h0);
    run(0, 1, 0, 3'd1, 32'h0000_0012, 32'h0,        32'hFFFF80FF, 0, 3, 1, 8'h04, 4'h0, 32'h0,        8'h00, 4'h0, 32'h0);
    run(0, 1, 0, 3'd5, 32'h0000_0012, 32'h0,        32'h000080FF, 0, 3, 1, 8'h04, 4'h0, 32'h0,        8'h00, 4'h0, 32'h0);
    // split halfword store and its read-back
    run(0, 0, 1, 3'd1, 32'h0000_000B, 32'h0000A55A, 32'h0000_0000, 0, 3, 2, 8'h02, 4'h8, 32'h5A000000, 8'h03, 4'h1, 32'h000000A5);
    run(0, 1, 0, 3'd5, 32'h0000_000B, 32'h0,        32'h0000A55A, 0, 4, 2, 8'h02, 4'h0, 32'h0,        8'h03, 4'h0, 32'h0);
    // byte store into lane 2 keeps the other lanes, then signed read-back
    run(0, 0, 1, 3'd0, 32'h0000_000E, 32'hFFFFFF99, 32'h0000_0000, 0, 2, 1, 8'h03, 4'h4, 32'hFF990000, 8'h00, 4'h0, 32'h0);
    run(0, 1, 0, 3'd0, 32'h0000_000E, 32'h0,        32'hFFFFFF99, 0, 3, 1, 8'h03, 4'h0, 32'h0,        8'h00, 4'h0, 32'h0);
    run(0, 1, 0, 3'd2, 32'h0000_000C, 32'h0,        32'h009900A5, 0, 3, 1, 8'h03, 4'h0, 32'h0,        8'h00, 4'h0, 32'h0);
    // word-address wrap from 0xFF to 0x00
    run(0, 0, 1, 3'd2, 32'h0000_03FC, 32'h44332211, 32'h0000_0000, 0, 2, 1, 8'hFF, 4'hF, 32'h44332211, 8'h00, 4'h0, 32'h0);
    run(0, 0, 1, 3'd2, 32'h0000_0000, 32'h88776655, 32'h0000_0000, 0, 2, 1, 8'h00, 4'hF, 32'h88776655, 8'h00, 4'h0, 32'h0);
    run(0, 1, 0, 3'd2, 32'h0000_03FE, 32'h0,        32'h66554433, 0, 4, 2, 8'hFF, 4'h0, 32'h0,        8'h00, 4'h0, 32'h0);
    run(0, 1, 0, 3'd1, 32'h0000_03FF, 32'h0,        32'h00005544, 0, 4, 2, 8'hFF, 4'h0, 32'h0,        8'h00, 4'h0, 32'h0);
    // upper byte-address bits are ignored
    run(0, 1, 0, 3'd4, 32'hABCD_03FF, 32'h0,        32'h00000044, 0, 3, 1, 8'hFF, 4'h0, 32'h0,        8'h00, 4'h0, 32'h0);
    // illegal requests
    run(0, 1, 0, 3'd3, 32'h0000_0010, 32'h0,        32'h0000_0000, 1, 1, 0, 8'h00, 4'h0, 32'h0,        8'h00, 4'h0, 32'h0);
    run(0, 0, 1, 3'd4, 32'h0000_0010, 32'h12345678, 32'h0000_0000, 1, 1, 0, 8'h00, 4'h0, 32'h0,        8'h00, 4'h0, 32'h0);
    run(0, 1, 1, 3'd2, 32'h0000_0010, 32'h12345678, 32'h0000_0000, 1, 1, 0, 8'h00, 4'h0, 32'h0,        8'h00, 4'h0, 32'h0);
    // SPLIT_EN=0 instance
    run(1, 1, 0, 3'd2, 32'h0000_0001, 32'h0,        32'h0000_0000, 1, 1, 0, 8'h00, 4'h0, 32'h0,        8'h00, 4'h0, 32'h0);
    run(1, 1, 0, 3'd2, 32'h0000_0000, 32'h0,        32'hCAFEF00D, 0, 3, 1, 8'h00, 4'h0, 32'h0,        8'h00, 4'h0, 32'h0);
    run(1, 1, 0, 3'd5, 32'h0000_0002, 32'h0,        32'h0000CAFE, 0, 3, 1, 8'h00, 4'h0, 32'h0,        8'h00, 4'h0, 32'h0);

    // req_valid with neither flag is ignored
    @(negedge clk);
    drive(1'b1, 1'b0, 1'b0, 1'b0, 3'd2, 32'h0000_0010, 32'h0);
    @(negedge clk);
    chk("ignored req_ready", {31'b0, ifa.req_ready}, 32'h1);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 32'h0, 32'h0);
    repeat (4) @(negedge clk);

    // reset during ACC1 of a split store: word0 written, word1 never touched
    c = cyc;
    aqa.push_back('{8'h08, 4'hE, 32'h22334400, c + 1});
    drive(1'b1, 1'b0, 1'b0, 1'b1, 3'd2, 32'h0000_0021, 32'h11223344);
    @(posedge clk);
    #1 drive(1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 32'h0, 32'h0);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst req_ready", {31'b0, ifa.req_ready}, 32'h1);
    chk("midrst mem_en", {31'b0, ifa.mem_en}, 32'h0);
    chk("midrst mem_we", {28'b0, ifa.mem_we}, 32'h0);
    chk("midrst mem_addr", {24'b0, ifa.mem_addr}, 32'h0);
    chk("midrst mem_wdata", ifa.mem_wdata, 32'h0);
    chk("midrst resp_valid", {31'b0, ifa.resp_valid}, 32'h0);
    chk("midrst pending", aqa.size(), 32'h0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    run(0, 1, 0, 3'd2, 32'h0000_0024, 32'h0,        32'h0000_0000, 0, 3, 1, 8'h09, 4'h0, 32'h0,        8'h00, 4'h0, 32'h0);
    run(0, 1, 0, 3'd2, 32'h0000_0020, 32'h0,        32'h22334400, 0, 3, 1, 8'h08, 4'h0, 32'h0,        8'h00, 4'h0, 32'h0);
    run(0, 0, 1, 3'd2, 32'h0000_0024, 32'h12345678, 32'h0000_0000, 0, 2, 1, 8'h09, 4'hF, 32'h12345678, 8'h00, 4'h0, 32'h0);
    run(0, 1, 0, 3'd2, 32'h0000_0024, 32'h0,        32'h12345678, 0, 3, 1, 8'h09, 4'h0, 32'h0,        8'h00, 4'h0, 32'h0);

    repeat (2) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, time limit reached");
    $fatal(1);
  end

endmodule

// File: doc/lsu_mem_port.md
Name: lsu_mem_port

Overview:
- Load/store unit between the execute stage and the data memory.
- Takes one load or store per request (func3 sizes: byte, halfword, word, plus the unsigned load variants).
- Drives a word-addressed synchronous block RAM port with byte enables, one-cycle read latency.
- Splits misaligned accesses that cross a word boundary into two word accesses; merges, sign-extends and returns load data; holds the pipeline via req_ready while busy.

Parameters:
- ADDR_W, 8, word-address width of the RAM port (2^ADDR_W words); byte address bits above ADDR_W+1 are ignored.
- SPLIT_EN, 1, 1 = split word-crossing accesses; 0 = word-crossing access returns err without touching memory.

Ports:
- clk  input  1  clock, all state on rising edge
- rst_n  input  1  asynchronous active-low reset
- req_valid  input  1  request present
- req_ready  output  1  unit idle and able to accept
- MemRead  input  1  load request
- MemWrite  input  1  store request
- func3  input  3  0 byte, 1 half, 2 word, 4 ubyte, 5 uhalf
- addr  input  32  byte address
- w_data  input  32  store data, right-aligned
- resp_valid  output  1  one-cycle completion pulse
- r_data  output  32  extended load data, valid with resp_valid
- err  output  1  illegal request, valid with resp_valid
- mem_en  output  1  RAM access this cycle
- mem_addr  output  ADDR_W  RAM word address
- mem_we  output  4  byte write enables (0 = read)
- mem_wdata  output  32  lane-aligned write data
- mem_rdata  input  32  RAM read data, valid the cycle after mem_en with mem_we=0

Behaviour:
- Clocking and reset: one clock; reset is asynchronous and active-low (clk, rst_n).
- Reset values: state IDLE, req_ready=1, all other outputs 0, internal latches cleared.
- Reset mid-operation aborts the access; no further mem_en; any partial split store is not completed.
- Accept rule: accept when req_valid && req_ready && (MemRead || MemWrite).
  - Latch func3, addr, w_data, read/write flag.
  - req_valid with neither flag set is ignored.
- req_ready = (state == IDLE).
- Sizes: 1 byte for func3 0/4, 2 bytes for 1/5, 4 bytes for 2. off = addr[1:0]; split = (off + size > 4).
- Illegal requests give an error response: both MemRead and MemWrite set, func3 in {3,6,7}, store with func3 4/5, or split with SPLIT_EN=0.
  - Path: IDLE -> RESP with err=1, r_data=0, no mem_en.
- Byte enables: be8 = ((1<<size)-1) << off (8 bits).
  - Word0: mem_addr = addr[ADDR_W+1:2], mem_we = be8[3:0] for stores.
  - Word1: mem_addr = word0+1, modulo 2^ADDR_W (wraps), mem_we = be8[7:4].
  - Store data: wd64 = {32'b0, w_data} << 8*off; word0 gets wd64[31:0], word1 gets wd64[63:32].
- FSM states: IDLE, ACC0, ACC1, CAP, RESP.
  - IDLE -> ACC0 on legal accept.
  - ACC0: mem_en=1, word0. Go to ACC1 if split; else CAP if load; else RESP.
  - ACC1: mem_en=1, word1. If load, latch mem_rdata as lo. Then CAP if load, else RESP.
  - CAP: latch mem_rdata (hi if split, lo otherwise). Go to RESP.
  - RESP: resp_valid=1 for exactly one cycle. Go to IDLE.
- Load merge: rd = ({hi, lo} >> 8*off)[31:0]. r_data by func3:
  - 0: sign-extend rd[7:0]
  - 1: sign-extend rd[15:0]
  - 2: rd
  - 4: zero-extend rd[7:0]
  - 5: zero-extend rd[15:0]
- r_data and err are driven only during RESP, 0 otherwise. Stores return r_data=0.
- Latency, with accept at cycle T, resp_valid at:
  - aligned store: T+2
  - split store: T+3
  - aligned load: T+3
  - split load: T+4
  - error: T+1
- Throughput: next accept is the cycle after RESP. No response backpressure.
- mem_we is 0 in every cycle where mem_en=0, and on all load accesses.

Test Plan:
- Aligned store: sw addr=0x10, w_data=0xDEADBEEF -> single mem_en cycle at T+1 with mem_addr=0x04, mem_we=4'hF, mem_wdata=0xDEADBEEF; resp_valid at T+2, err=0; req_ready low T+1..T+2.
- Byte loads: RAM word 0x04 = 0x80FF1122.
  - lb addr=0x13 -> r_data=0xFFFFFF80 at T+3.
  - lbu addr=0x13 -> 0x00000080.
  - lh addr=0x12 -> 0xFFFF80FF.
- Split store: sh addr=0x0B, w_data=0x0000A55A.
  - T+1: mem_addr=0x02, mem_we=4'b1000, mem_wdata=0x5A000000.
  - T+2: mem_addr=0x03, mem_we=4'b0001, mem_wdata=0x000000A5.
  - resp_valid at T+3.
- Split load with wrap: ADDR_W=8, word 0xFF=0x44332211, word 0x00=0x88776655, lw addr=0x3FE -> reads word 0xFF then 0x00; r_data=0x66554433 at T+4.
- Illegal requests: lw with func3=3, and sw with func3=4 -> no mem_en, resp_valid at T+1 with err=1, r_data=0. With SPLIT_EN=0, lw addr=0x01 -> err=1.
- Mid-op reset: assert rst_n=0 during ACC1 of a split store -> all outputs 0 immediately, req_ready=1, no mem_en after release; a subsequent sw is accepted and completes normally.
